pp_gen_pipe: RTL and testbench

Parametrised, pipelined partial-product generator for the Dadda multiplier datapath. It accepts one WIDTH x WIDTH operand pair per cycle over a valid/ready handshake and produces all WIDTH partial-product rows. Rows are either plain AND terms (unsigned) or Baugh-Wooley-modified terms (signed). Results are held in a 2-entry output buffer so downstream reduction-tree back-pressure never drops an operation. The block sits between the operand source and the Dadda reduction stages, and supersedes the fixed 8x8 combinational generator.

---
 rtl/pp_gen_pipe.sv | 154 +++++++++++++++
 tb/tb_pp_gen_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pp_gen_pipe.sv
// ---------------------------------------------------------------------------
// pp_gen_pipe
//
// Pipelined partial-product generator that feeds the Dadda reduction tree.
// It accepts one WIDTH x WIDTH operand pair per cycle over a valid/ready
// handshake and forms all WIDTH partial-product rows in one AND/XOR level.
// Rows are plain AND terms (unsigned) or Baugh-Wooley terms (signed). Results
// wait in a 2-entry output buffer, so reduction-tree back-pressure never
// drops an operation.
//
// Parameters
//   WIDTH      operand width in bits (4..32)
//   SIGNED_EN  1 enables signed (Baugh-Wooley) rows; 0 ties signed mode off
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operand pair present
//   in_ready     block can accept a pair this cycle (from registered count)
//   a, b         multiplicand / multiplier
//   signed_mode  sampled with a/b; 1 = two's-complement operands
//   out_valid    buffer head holds a result
//   out_ready    consumer takes the head this cycle
//   pp           flattened rows, pp[i*WIDTH+j] = row i bit j, weight 2^i
//   pp_signed    head was built with Baugh-Wooley rows; the tree adds a 1 at
//                columns WIDTH and 2*WIDTH-1
//   pp_zero      head operand pair had a == 0 or b == 0
// ---------------------------------------------------------------------------
module pp_gen_pipe #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic                     signed_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*WIDTH-1:0]   pp,
    output logic                     pp_signed,
    output logic                     pp_zero
);

    localparam int N = WIDTH * WIDTH;

    // Buffer storage: slot 0 is always the head, slot 1 the entry behind it.
    logic [1:0]   count_q, count_d;
    logic [N-1:0] head_pp_q, head_pp_d;
    logic         head_sgn_q, head_sgn_d;
    logic         head_zero_q, head_zero_d;
    logic [N-1:0] tail_pp_q, tail_pp_d;
    logic         tail_sgn_q, tail_sgn_d;
    logic         tail_zero_q, tail_zero_d;

    logic         eff_signed;
    logic [N-1:0] rows_new;
    logic         zero_new;
    logic         push;
    logic         pop;

    assign eff_signed = signed_mode & SIGNED_EN;
    assign zero_new   = (a == '0) | (b == '0);

    // Row generation. In signed mode the terms of the last row and the last
    // column are inverted, except the corner term where both hold: those
    // carry the sign weight and become positive once the tree adds the two
    // Baugh-Wooley constants.
    always_comb begin
        rows_new = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                rows_new[i*WIDTH+j] = (a[j] & b[i])
                                    ^ (eff_signed & ((i == WIDTH-1) != (j == WIDTH-1)));
            end
        end
    end

    // Handshake flags come only from the registered count, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Buffer next state. A pop shifts the tail forward (or clears the head
    // when it was the only entry) so vacated slots always read as zero. A
    // push then lands in the first free slot, which at count 1 with a
    // simultaneous pop is the head itself.
    always_comb begin
        count_d     = count_q;
        head_pp_d   = head_pp_q;
        head_sgn_d  = head_sgn_q;
        head_zero_d = head_zero_q;
        tail_pp_d   = tail_pp_q;
        tail_sgn_d  = tail_sgn_q;
        tail_zero_d = tail_zero_q;

        if (pop) begin
            head_pp_d   = tail_pp_q;
            head_sgn_d  = tail_sgn_q;
            head_zero_d = tail_zero_q;
            tail_pp_d   = '0;
            tail_sgn_d  = 1'b0;
            tail_zero_d = 1'b0;
        end

        if (push) begin
            if ((count_q == 2'd0) || pop) begin
                head_pp_d   = rows_new;
                head_sgn_d  = eff_signed;
                head_zero_d = zero_new;
            end else begin
                tail_pp_d   = rows_new;
                tail_sgn_d  = eff_signed;
                tail_zero_d = zero_new;
            end
        end

        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // State registers; reset discards every in-flight entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= 2'd0;
            head_pp_q   <= '0;
            head_sgn_q  <= 1'b0;
            head_zero_q <= 1'b0;
            tail_pp_q   <= '0;
            tail_sgn_q  <= 1'b0;
            tail_zero_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            head_pp_q   <= head_pp_d;
            head_sgn_q  <= head_sgn_d;
            head_zero_q <= head_zero_d;
            tail_pp_q   <= tail_pp_d;
            tail_sgn_q  <= tail_sgn_d;
            tail_zero_q <= tail_zero_d;
        end
    end

    assign pp        = head_pp_q;
    assign pp_signed = head_sgn_q;
    assign pp_zero   = head_zero_q;

endmodule

// File: tb/tb_pp_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_pp_gen_pipe
//
// Drives two generators (signed mode enabled and disabled) from the same
// operand stream and compares their outputs with a queue-based model of the
// output buffer. Expected rows are built word-wise (row i = b[i] ? a : 0,
// then the Baugh-Wooley inversion masks), and each head is also checked
// arithmetically: sum(row_i << i) plus the signed constants must equal a*b.
// ---------------------------------------------------------------------------
module tb_pp_gen_pipe;

    localparam int W = 8;
    localparam int N = W * W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         signed_mode;
    logic         out_ready;

    logic         in_ready_s, out_valid_s, pp_signed_s, pp_zero_s;
    logic [N-1:0] pp_s;
    logic         in_ready_u, out_valid_u, pp_signed_u, pp_zero_u;
    logic [N-1:0] pp_u;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           s;
    } entry_t;

    entry_t modelQ[$];
    int     compareCount = 0;
    int     failCount    = 0;
    logic [W-1:0] ra, rb;
    bit           rs;

    always #5 clk = ~clk;

    pp_gen_pipe #(.WIDTH(W), .SIGNED_EN(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid_s),
        .out_ready(out_ready), .pp(pp_s), .pp_signed(pp_signed_s), .pp_zero(pp_zero_s)
    );

    pp_gen_pipe #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid_u),
        .out_ready(out_ready), .pp(pp_u), .pp_signed(pp_signed_u), .pp_zero(pp_zero_u)
    );

    // Single comparison point: counts, asserts and reports.
    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Word-level rows: row i is a when b[i] is set; signed mode flips the
    // MSB of rows 0..W-2 and every bit but the MSB of row W-1.
    function automatic logic [N-1:0] expRows(input logic [W-1:0] ea, input logic [W-1:0] eb, input bit s);
        logic [N-1:0] r = '0;
        logic [W-1:0] row;
        logic [W-1:0] msbMask = {1'b1, {(W-1){1'b0}}};
        for (int i = 0; i < W; i++) begin
            row = eb[i] ? ea : '0;
            if (s) row = (i == W-1) ? (row ^ ~msbMask) : (row ^ msbMask);
            r[i*W +: W] = row;
        end
        return r;
    endfunction

    function automatic logic [2*W-1:0] rowSum(input logic [N-1:0] p, input bit s);
        longint acc = 0;
        for (int i = 0; i < W; i++) acc += longint'(p[i*W +: W]) << i;
        if (s) acc += (longint'(1) << W) + (longint'(1) << (2*W-1));
        return acc[2*W-1:0];
    endfunction

    function automatic logic [2*W-1:0] product(input logic [W-1:0] pa, input logic [W-1:0] pb, input bit s);
        longint prod;
        if (s) prod = longint'($signed(pa)) * longint'($signed(pb));
        else   prod = longint'(pa) * longint'(pb);
        return prod[2*W-1:0];
    endfunction

    // Compare both DUTs against the model head and handshake flags.
    task automatic checkOutput(input string tag);
        entry_t h;
        logic   expValid = (modelQ.size() != 0);
        logic   expReady = (modelQ.size() != 2);
        checkVal({tag, ".out_valid_s"}, out_valid_s, expValid);
        checkVal({tag, ".in_ready_s"},  in_ready_s,  expReady);
        checkVal({tag, ".out_valid_u"}, out_valid_u, expValid);
        checkVal({tag, ".in_ready_u"},  in_ready_u,  expReady);
        if (expValid) begin
            h = modelQ[0];
            checkVal({tag, ".pp_s"},        pp_s,        expRows(h.a, h.b, h.s));
            checkVal({tag, ".pp_signed_s"}, pp_signed_s, h.s);
            checkVal({tag, ".pp_zero_s"},   pp_zero_s,   (h.a == 0) || (h.b == 0));
            checkVal({tag, ".sum_s"},       rowSum(pp_s, h.s), product(h.a, h.b, h.s));
            checkVal({tag, ".pp_u"},        pp_u,        expRows(h.a, h.b, 1'b0));
            checkVal({tag, ".pp_signed_u"}, pp_signed_u, 1'b0);
            checkVal({tag, ".pp_zero_u"},   pp_zero_u,   (h.a == 0) || (h.b == 0));
            checkVal({tag, ".sum_u"},       rowSum(pp_u, 1'b0), product(h.a, h.b, 1'b0));
        end else begin
            checkVal({tag, ".pp_s_idle"},    {pp_signed_s, pp_zero_s, pp_s[61:0]}, 64'd0);
            checkVal({tag, ".pp_s_idle_hi"}, pp_s[63:62], 64'd0);
            checkVal({tag, ".pp_u_idle"},    pp_u, 64'd0);
        end
    endtask

    // Drive one cycle of inputs and advance the model by the same handshake.
    task automatic applyStimulus(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic ism, input logic ordy);
        bit doPop, doPush;
        in_valid    = iv;
        a           = ia;
        b           = ib;
        signed_mode = ism;
        out_ready   = ordy;
        doPop  = (modelQ.size() != 0) && ordy;
        doPush = iv && (modelQ.size() != 2);
        @(posedge clk);
        #1;
        if (doPop)  modelQ.delete(0);
        if (doPush) modelQ.push_back(entry_t'{ia, ib, ism});
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b0;
        #12;
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("idle");

        $display("[TB] directed row patterns");
        applyStimulus(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1);
        checkOutput("uns_ff_01");
        checkVal("uns_ff_01.const", pp_s, 64'h0000_0000_0000_00FF);
        applyStimulus(1'b1, 8'h80, 8'h80, 1'b1, 1'b1);
        checkOutput("sgn_80_80");
        checkVal("sgn_80_80.const_s", pp_s, 64'hFF80_8080_8080_8080);
        checkVal("sgn_80_80.const_u", pp_u, 64'h8000_0000_0000_0000);
        checkVal("sgn_80_80.flag_s",  pp_signed_s, 1'b1);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        checkOutput("drain1");

        $display("[TB] back-pressure");
        applyStimulus(1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
        checkOutput("bp1");
        checkVal("bp1.row0", pp_s[7:0], 8'h01);
        applyStimulus(1'b1, 8'd2, 8'd1, 1'b0, 1'b0);
        checkOutput("bp2");
        checkVal("bp2.in_ready_low", in_ready_s, 1'b0);
        applyStimulus(1'b1, 8'd3, 8'd1, 1'b0, 1'b0);
        checkOutput("bp3_held");
        checkVal("bp3.row0_still1", pp_s[7:0], 8'h01);
        applyStimulus(1'b1, 8'd3, 8'd1, 1'b0, 1'b1);
        checkOutput("bp_pop1");
        checkVal("bp_pop1.row0", pp_s[7:0], 8'h02);
        applyStimulus(1'b1, 8'd3, 8'd1, 1'b0, 1'b1);
        checkOutput("bp_pop2");
        checkVal("bp_pop2.row0", pp_s[7:0], 8'h03);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
        checkOutput("bp_drain");

        $display("[TB] zero operands");
        applyStimulus(1'b1, 8'h00, 8'h5A, 1'b1, 1'b1);
        checkOutput("zero_a_sgn");
        checkVal("zero_a_sgn.flag", pp_zero_s, 1'b1);
        applyStimulus(1'b1, 8'hA5, 8'h00, 1'b0, 1'b1);
        checkOutput("zero_b_uns");
        checkVal("zero_b_uns.rows", pp_s, 64'd0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
        checkOutput("zero_drain");

        $display("[TB] random push/pop at count 1");
        applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        checkOutput("rnd_prime");
        for (int k = 0; k < 100; k++) begin
            ra = ($urandom_range(0, 9) == 0) ? '0 : 8'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? '0 : 8'($urandom);
            rs = 1'($urandom);
            applyStimulus(1'b1, ra, rb, rs, 1'b1);
            checkOutput("rnd");
            checkVal("rnd.count1", {out_valid_s, in_ready_s}, 2'b11);
        end
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
        checkOutput("rnd_drain");

        $display("[TB] asynchronous reset mid-stream");
        applyStimulus(1'b1, 8'h3C, 8'hC3, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h7E, 8'h81, 1'b0, 1'b0);
        checkOutput("rst_full");
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        modelQ.delete();
        checkVal("rst_async.out_valid", out_valid_s, 1'b0);
        checkVal("rst_async.in_ready",  in_ready_s,  1'b1);
        checkVal("rst_async.pp",        pp_s,        64'd0);
        checkVal("rst_async.flags",     {pp_signed_s, pp_zero_s}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        checkOutput("post_reset");
        applyStimulus(1'b1, 8'h12, 8'h34, 1'b1, 1'b1);
        checkOutput("post_reset_op");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
